out_buffer: RTL and testbench
=============================

OUT_BUFFER -- requirements
Module: out_buffer

Interface
REQ-001 Parameter DWIDTH, default 32, data word width; SHALL match the downstream I/O controller data width.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RETRY, default 4, cycles to wait for out_busy after a request before re-requesting.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  core OUT instruction pushes wr_data this cycle.
REQ-007 wr_data  input  DWIDTH  word to transmit.
REQ-008 full  output  1  FIFO holds DEPTH words.
REQ-009 count  output  log2(DEPTH)+1  words currently stored.
REQ-010 ovf  output  1  sticky flag: a write was dropped.
REQ-011 clr_ovf  input  1  clears ovf.
REQ-012 out_req  output  1  request to the I/O controller OUT path.
REQ-013 out_data  output  DWIDTH  word offered with out_req.
REQ-014 out_busy  input  1  I/O controller OUT path busy; rises the cycle after an accepted request and falls when the UART write completes.

Function
REQ-015 Storage SHALL be a circular FIFO with rd_ptr/wr_ptr wrapping modulo DEPTH; full = (count==DEPTH); count SHALL be registered.
REQ-016 wr_en with full=0 SHALL store wr_data at wr_ptr and increment wr_ptr; the word is counted from the next cycle.
REQ-017 wr_en with full=1 SHALL drop the word, leave pointers unchanged, and set ovf next cycle; this holds even when a pop occurs in the same cycle.
REQ-018 clr_ovf SHALL clear ovf next cycle; simultaneous clr_ovf and overflowing write SHALL leave ovf=1.
REQ-019 Drain FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> REQ when count!=0 and out_busy==0; otherwise stay.
REQ-021 REQ: out_req=1 for exactly this one cycle; unconditional -> WAIT_BUSY with retry counter cleared.
REQ-022 WAIT_BUSY: out_busy==1 -> WAIT_DONE; else increment counter and, after RETRY cycles without out_busy, -> IDLE (head word is not popped, so it is re-requested).
REQ-023 WAIT_DONE: out_busy==0 -> pop (increment rd_ptr, decrement count) and -> IDLE; else stay.
REQ-024 out_req SHALL be 0 in every state other than REQ.
REQ-025 out_data SHALL equal mem[rd_ptr] and SHALL be stable from REQ through the pop cycle.
REQ-026 Simultaneous push (full=0) and pop SHALL leave count unchanged and update both pointers.
REQ-027 Each word SHALL be sent exactly once and in write order; throughput is bounded by out_busy, and the minimum request-to-request spacing is 4 cycles.
REQ-028 Illegal FSM encodings SHALL return to IDLE next cycle.

Reset
REQ-029 rstn=0 at a clock edge SHALL set rd_ptr=wr_ptr=0, count=0, full=0, ovf=0, out_req=0, retry counter=0, and FSM=IDLE.
REQ-030 Reset mid-transaction (any state) SHALL discard all stored words; FIFO contents need not be cleared.
REQ-031 out_data is don't-care while count==0.

Verification
REQ-032 Single word: push 0x00000041 to an idle model; out_req pulses once with out_data=0x41; model raises out_busy for 5 cycles -> count returns to 0 one cycle after out_busy falls, and no second out_req.
REQ-033 Burst: push 0x1..0x10 back-to-back (DEPTH=16) -> full=1 after the 16th; push 0x11 -> dropped, ovf=1; drained order is 0x1..0x10; clr_ovf -> ovf=0.
REQ-034 No response: model ignores out_req -> out_req repeats every RETRY+2 cycles with the same out_data, and count stays 1.
REQ-035 Busy at entry: out_busy held high (IN/OUT contention) while count=1 -> no out_req until out_busy falls, then a request on the next REQ cycle.
REQ-036 Push while draining: push during WAIT_DONE while the pop cycle coincides -> count unchanged, and the pushed word is sent next.
REQ-037 Reset in WAIT_DONE with count=3 -> count=0, out_req=0, and no further requests.

Source files
------------

// File: rtl/out_buffer.sv
// Output FIFO between the core's OUT instruction and the I/O controller OUT path.
// Words are drained one at a time with a request/busy handshake and a retry timeout.
module out_buffer #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RETRY  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic                     out_req,
  output logic [DWIDTH-1:0]        out_data,
  input  logic                     out_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (RETRY > 1) ? $clog2(RETRY) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [RW-1:0]       retry_cnt;
  logic [RW-1:0]       retry_nxt;
  logic                pop;
  logic                push;
  logic [CW-1:0]       count_nxt;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [DWIDTH-1:0]   mem [DEPTH];

  assign push      = wr_en & ~full;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Drain FSM: state register, retry counter and registered request strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      retry_cnt <= '0;
      out_req   <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      out_req   <= (state_nxt == REQ);
    end
  end

  // Drain FSM: next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if ((count != '0) && !out_busy) state_nxt = REQ;
      REQ:       state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (out_busy)                          state_nxt = WAIT_DONE;
        else if (retry_cnt == RW'(RETRY - 1))  state_nxt = IDLE;
      end
      WAIT_DONE: if (!out_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Drain FSM: pop strobe and retry counter update
  always_comb begin
    pop       = 1'b0;
    retry_nxt = retry_cnt;
    case (state)
      REQ:       retry_nxt = '0;
      WAIT_BUSY: begin
        if (!out_busy)
          retry_nxt = (retry_cnt == RW'(RETRY - 1)) ? '0 : retry_cnt + RW'(1);
      end
      WAIT_DONE: pop = ~out_busy;
      default:   ;
    endcase
  end

  // Storage array; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, sticky overflow and the head word offered downstream
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      ovf      <= 1'b0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      ovf      <= (ovf & ~clr_ovf) | (wr_en & full);
      out_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_out_buffer.sv
// Scoreboard bench for out_buffer: queue-based reference FIFO, reactive I/O controller
// model with ignore/contention modes, and a monitor comparing every cycle.
module tb_out_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RETRY = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          wr_en    = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          clr_ovf  = 1'b0;
  logic          out_busy = 1'b0;
  logic          full;
  logic          ovf;
  logic          out_req;
  logic [CW-1:0] count;
  logic [DW-1:0] out_data;

  out_buffer #(.DWIDTH(DW), .DEPTH(DEPTH), .RETRY(RETRY)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf),
    .out_req  (out_req),
    .out_data (out_data),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;

  logic [DW-1:0] exp_q [$];
  logic          ovf_m = 1'b0;
  logic          m_acc;
  logic          m_drop;

  // controller model controls and state
  logic ignore_all = 1'b0;
  logic rand_ign   = 1'b0;
  logic contend_en = 1'b0;
  logic force_busy = 1'b0;
  int   fixed_len  = 0;
  logic xfer       = 1'b0;
  logic pop_exp    = 1'b0;
  logic last_ign   = 1'b0;
  logic quiet      = 1'b0;
  int   bcnt       = 0;
  int   ccnt       = 0;
  int   since      = 100;
  int   req_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FIFO: a word is accepted if there was room before any pop this edge
  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      m_acc  = wr_en && (exp_q.size() < DEPTH);
      m_drop = wr_en && !m_acc;
      if (pop_exp && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back(wr_data);
      ovf_m = m_drop | (ovf_m & ~clr_ovf);
    end
  end

  // I/O controller model: busy rises the cycle after an accepted request
  always @(negedge clk) begin
    pop_exp = 1'b0;
    if (!rstn) begin
      xfer = 1'b0; bcnt = 0; ccnt = 0; out_busy = 1'b0; since = 100;
    end else begin
      since++;
      if (xfer) begin
        if (bcnt > 0) begin
          out_busy = 1'b1; bcnt--;
        end else begin
          out_busy = 1'b0; xfer = 1'b0; pop_exp = 1'b1;
        end
      end else if (force_busy || ccnt > 0) begin
        out_busy = 1'b1; quiet = 1'b0;
        if (ccnt > 0) ccnt--;
      end else begin
        out_busy = 1'b0;
        // contention only starts once any ignored request has timed out
        if (contend_en && !out_req && since > RETRY && $urandom_range(0, 19) == 0) begin
          ccnt = $urandom_range(0, 4); out_busy = 1'b1; quiet = 1'b0;
        end
      end
      if (out_req) begin
        since = 0;
        if (!ignore_all && !(rand_ign && $urandom_range(0, 3) == 0)) begin
          xfer = 1'b1;
          bcnt = (fixed_len > 0) ? fixed_len : $urandom_range(1, 6);
          last_ign = 1'b0;
        end else begin
          last_ign = 1'b1; quiet = 1'b1;
        end
      end
    end
  end

  // Monitor: sampled shortly after each rising edge
  initial begin : monitor
    int cyc;
    int last_req;
    bit have_last;
    cyc = 0; last_req = 0; have_last = 0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (!rstn) have_last = 0;
      check("count", 64'(count), 64'(exp_q.size()));
      check("full", 64'(full), 64'(exp_q.size() == DEPTH));
      check("ovf", 64'(ovf), 64'(ovf_m));
      if (xfer && exp_q.size() > 0) check("data_hold", 64'(out_data), 64'(exp_q[0]));
      if (out_req) begin
        req_cnt++;
        if (exp_q.size() == 0) check("spurious_req", 64'(out_req), 64'(0));
        else                   check("req_data", 64'(out_data), 64'(exp_q[0]));
        if (have_last) begin
          check("req_spacing", 64'((cyc - last_req) >= 4), 64'(1));
          if (last_ign && quiet) check("retry_gap", 64'(cyc - last_req), 64'(RETRY + 2));
        end
        have_last = 1; last_req = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || xfer) && n < 3000) begin
      tick(1); n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int req0;
    int found;
    logic [CW-1:0] cnt_before;

    tick(3);
    rstn = 1'b1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_full", 64'(full), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_req", 64'(out_req), 64'(0));

    // single word with a 5-cycle busy
    fixed_len = 5;
    req0 = req_cnt;
    push(32'h0000_0041);
    tick(20);
    check("single_reqs", 64'(req_cnt - req0), 64'(1));
    check("single_count", 64'(count), 64'(0));
    fixed_len = 0;

    // burst fill while the controller ignores requests, then overflow and drain
    ignore_all = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      tick(1);
    end
    check("burst_full", 64'(full), 64'(1));
    wr_data = 32'h11;
    tick(1);
    wr_en = 1'b0;
    check("burst_ovf", 64'(ovf), 64'(1));
    check("burst_count", 64'(count), 64'(16));
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("clr_ovf", 64'(ovf), 64'(0));
    ignore_all = 1'b0;
    wait_drain("burst");

    // controller never answers: periodic re-request of the same head word
    do_reset();
    ignore_all = 1'b1;
    req0 = req_cnt;
    push(32'h0000_005A);
    tick(40);
    check("noresp_reqs", 64'((req_cnt - req0) >= 5), 64'(1));
    check("noresp_count", 64'(count), 64'(1));
    ignore_all = 1'b0;
    wait_drain("noresp");

    // controller busy with something else when a word arrives
    force_busy = 1'b1;
    tick(2);
    req0 = req_cnt;
    push(32'h0000_0077);
    tick(12);
    check("busy_hold_reqs", 64'(req_cnt - req0), 64'(0));
    check("busy_hold_count", 64'(count), 64'(1));
    force_busy = 1'b0;
    tick(3);
    check("busy_release_req", 64'(req_cnt - req0), 64'(1));
    wait_drain("busy");

    // push landing on the pop cycle
    fixed_len = 3;
    wr_en = 1'b1; wr_data = 32'hA0A0_0001; tick(1);
    wr_data = 32'hA0A0_0002; tick(1);
    wr_en = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk); #1;
      if (pop_exp) found = 1;
    end
    check("pushpop_found", 64'(found), 64'(1));
    cnt_before = count;
    wr_en = 1'b1; wr_data = 32'hA0A0_0003;
    tick(1);
    wr_en = 1'b0;
    check("pushpop_count", 64'(count), 64'(cnt_before));
    fixed_len = 0;
    wait_drain("pushpop");

    // randomized traffic with ignored requests and busy contention
    contend_en = 1'b1; rand_ign = 1'b1;
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = $urandom;
      clr_ovf = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    wr_en = 1'b0; clr_ovf = 1'b0; contend_en = 1'b0; rand_ign = 1'b0;
    wait_drain("random");

    // reset while a transfer is in flight with three words stored
    fixed_len = 8;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'hC0DE_0000 + DW'(i);
      tick(1);
    end
    wr_en = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick(1);
      if (xfer) found = 1;
    end
    tick(3);
    check("pre_rst_xfer", 64'(found), 64'(1));
    check("pre_rst_count", 64'(count), 64'(3));
    do_reset();
    req0 = req_cnt;
    check("post_rst_count", 64'(count), 64'(0));
    check("post_rst_req", 64'(out_req), 64'(0));
    tick(30);
    check("post_rst_reqs", 64'(req_cnt - req0), 64'(0));
    fixed_len = 0;

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
